key_seq_ctrl: RTL and testbench

KEY_SEQ_CTRL -- requirements
Module: key_seq_ctrl

---
 rtl/calc_pkg.sv | 42 ++++
 rtl/key_edge.sv | 25 ++
 rtl/key_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_key_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings for the calculator key sequencer
// Holds state codes, key codes, write-target and display-select encodings,
// plus the display-select mapping used by the sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'b000,
        ST_ENTRY_B = 3'b001,
        ST_RESULT  = 3'b010,
        ST_CLEAR   = 3'b011
    } state_t;

    // key codes (function keys have key_type = 1)
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'b1010;
    localparam logic [3:0] KEY_SUB       = 4'b1011;
    localparam logic [3:0] KEY_EQ        = 4'b1100;
    localparam logic [3:0] KEY_CLR       = 4'b1111;

    // reg_sel write targets
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_A    = 2'd1;
    localparam logic [1:0] SEL_B    = 2'd2;
    localparam logic [1:0] SEL_RES  = 2'd3;

    // oe display selects
    localparam logic [1:0] OE_BLANK = 2'd0;
    localparam logic [1:0] OE_A     = 2'd1;
    localparam logic [1:0] OE_B     = 2'd2;
    localparam logic [1:0] OE_RES   = 2'd3;

    // Display follows the operand being typed; an empty B still shows A.
    function automatic logic [1:0] oe_of(input state_t s, input logic cnt_zero);
        case (s)
            ST_ENTRY_A: return cnt_zero ? OE_BLANK : OE_A;
            ST_ENTRY_B: return cnt_zero ? OE_A : OE_B;
            ST_RESULT:  return OE_RES;
            default:    return OE_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - key press rising-edge detector
// Ports: clk, reset_n (async active-low), key_valid (key held), press (one
// cycle high on the first clock a key is seen held).
module key_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic key_valid,
    output logic press
);

    logic prev;

    // History resets to 1 so a key still held when reset releases is not
    // taken as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b1;
        end else begin
            prev <= key_valid;
        end
    end

    assign press = key_valid & ~prev;

endmodule

// File: rtl/key_seq_ctrl.sv
// rtl/key_seq_ctrl.sv - calculator keypad sequencer
// Ports: clk, reset_n (async active-low); key_valid/key_type/key_code keypad
// input; reg_sel, digit_we, digit_out, op_we, op_code, res_we, res_to_a, clr
// datapath controls; oe display select; overflow sticky flag; state debug.
module key_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic       key_type,
    input  logic [3:0] key_code,
    output logic [1:0] reg_sel,
    output logic       digit_we,
    output logic [3:0] digit_out,
    output logic       op_we,
    output logic       op_code,
    output logic       res_we,
    output logic       res_to_a,
    output logic       clr,
    output logic [1:0] oe,
    output logic       overflow,
    output logic [2:0] state
);

    logic             press;
    state_t           state_q, n_state;
    logic [CNT_W-1:0] cnt, n_cnt;
    logic [1:0]       n_sel;
    logic             n_dwe, n_owe, n_ocode, n_rwe, n_rta, n_clr, n_ovf;
    logic [3:0]       n_dout;
    logic             is_digit, is_op, is_eq, is_clr;

    key_edge u_key_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_valid (key_valid),
        .press     (press)
    );

    assign is_digit = !key_type && (key_code <= KEY_DIGIT_MAX);
    assign is_op    = key_type && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
    assign is_eq    = key_type && (key_code == KEY_EQ);
    assign is_clr   = key_type && (key_code == KEY_CLR);

    always_comb begin
        n_state = state_q;
        n_cnt   = cnt;
        n_sel   = SEL_NONE;
        n_dwe   = 1'b0;
        n_dout  = digit_out;
        n_owe   = 1'b0;
        n_ocode = op_code;
        n_rwe   = 1'b0;
        n_rta   = 1'b0;
        n_clr   = 1'b0;
        n_ovf   = overflow;

        case (state_q)
            ST_ENTRY_A, ST_ENTRY_B: begin
                if (press) begin
                    if (is_clr) begin
                        n_state = ST_CLEAR;
                    end else if (is_digit) begin
                        if (cnt < CNT_W'(DIGITS)) begin
                            n_dwe  = 1'b1;
                            n_sel  = (state_q == ST_ENTRY_A) ? SEL_A : SEL_B;
                            n_dout = key_code;
                            n_cnt  = cnt + CNT_W'(1);
                        end else begin
                            n_ovf = 1'b1;
                        end
                    end else if (is_op) begin
                        // A needs a digit before an operator; on an empty B
                        // the operator simply replaces the previous one.
                        if (state_q == ST_ENTRY_A && cnt != '0) begin
                            n_owe   = 1'b1;
                            n_ocode = key_code[0];
                            n_cnt   = '0;
                            n_state = ST_ENTRY_B;
                        end else if (state_q == ST_ENTRY_B && cnt == '0) begin
                            n_owe   = 1'b1;
                            n_ocode = key_code[0];
                        end
                    end else if (is_eq && state_q == ST_ENTRY_B && cnt != '0) begin
                        n_rwe   = 1'b1;
                        n_sel   = SEL_RES;
                        n_state = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (press) begin
                    if (is_clr) begin
                        n_state = ST_CLEAR;
                    end else if (is_op) begin
                        // chaining: result becomes A, then collect a new B
                        n_rta   = 1'b1;
                        n_owe   = 1'b1;
                        n_ocode = key_code[0];
                        n_cnt   = '0;
                        n_state = ST_ENTRY_B;
                    end
                end
            end
            ST_CLEAR: begin
                // any press edge in this cycle is dropped
                n_state = ST_ENTRY_A;
            end
            default: begin
                n_state = ST_CLEAR;
            end
        endcase

        // Entering CLEAR: the clear pulse and flag resets are visible together
        // in the CLEAR cycle itself.
        if (n_state == ST_CLEAR) begin
            n_clr   = 1'b1;
            n_cnt   = '0;
            n_ovf   = 1'b0;
            n_ocode = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ENTRY_A;
            cnt       <= '0;
            reg_sel   <= SEL_NONE;
            digit_we  <= 1'b0;
            digit_out <= 4'd0;
            op_we     <= 1'b0;
            op_code   <= 1'b0;
            res_we    <= 1'b0;
            res_to_a  <= 1'b0;
            clr       <= 1'b0;
            oe        <= OE_BLANK;
            overflow  <= 1'b0;
        end else begin
            state_q   <= n_state;
            cnt       <= n_cnt;
            reg_sel   <= n_sel;
            digit_we  <= n_dwe;
            digit_out <= n_dout;
            op_we     <= n_owe;
            op_code   <= n_ocode;
            res_we    <= n_rwe;
            res_to_a  <= n_rta;
            clr       <= n_clr;
            oe        <= oe_of(n_state, n_cnt == '0);
            overflow  <= n_ovf;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_key_seq_ctrl.sv
// tb/tb_key_seq_ctrl.sv - self-checking bench for key_seq_ctrl
module tb_key_seq_ctrl;

    localparam int DIGITS = 4;
    localparam int CNT_W  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_type = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [1:0] reg_sel;
    logic       digit_we;
    logic [3:0] digit_out;
    logic       op_we;
    logic       op_code;
    logic       res_we;
    logic       res_to_a;
    logic       clr;
    logic [1:0] oe;
    logic       overflow;
    logic [2:0] state;

    always #5 clk = ~clk;

    key_seq_ctrl #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_valid (key_valid),
        .key_type  (key_type),
        .key_code  (key_code),
        .reg_sel   (reg_sel),
        .digit_we  (digit_we),
        .digit_out (digit_out),
        .op_we     (op_we),
        .op_code   (op_code),
        .res_we    (res_we),
        .res_to_a  (res_to_a),
        .clr       (clr),
        .oe        (oe),
        .overflow  (overflow),
        .state     (state)
    );

    int n_vec = 0;
    int n_bad = 0;

    // expected outputs for the current sample
    logic [1:0] e_sel, e_oe;
    logic       e_dwe, e_owe, e_ocode, e_rwe, e_rta, e_clr, e_ovf;
    logic [3:0] e_dout;
    logic [2:0] e_state;

    typedef struct {
        logic       t;
        logic [3:0] c;
        int         hold;
        logic [1:0] sel;
        logic       dwe;
        logic [3:0] dout;
        logic       owe;
        logic       ocode;
        logic       rwe;
        logic       rta;
        logic       clr;
        logic [1:0] oe;
        logic       ovf;
        logic [2:0] st;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    // reference model: calculator phase plus the digits typed per operand
    int         m_phase;   // 0 entering A, 1 entering B, 2 showing result, 3 clearing
    int         qa [$];
    int         qb [$];
    logic       m_op;
    logic       m_ovf;
    logic [3:0] m_dout;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".reg_sel"},  8'(reg_sel),   8'(e_sel));
        cmp({tag, ".digit_we"}, 8'(digit_we),  8'(e_dwe));
        cmp({tag, ".digit_out"},8'(digit_out), 8'(e_dout));
        cmp({tag, ".op_we"},    8'(op_we),     8'(e_owe));
        cmp({tag, ".op_code"},  8'(op_code),   8'(e_ocode));
        cmp({tag, ".res_we"},   8'(res_we),    8'(e_rwe));
        cmp({tag, ".res_to_a"}, 8'(res_to_a),  8'(e_rta));
        cmp({tag, ".clr"},      8'(clr),       8'(e_clr));
        cmp({tag, ".oe"},       8'(oe),        8'(e_oe));
        cmp({tag, ".overflow"}, 8'(overflow),  8'(e_ovf));
        cmp({tag, ".state"},    8'(state),     8'(e_state));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_pulses();
        e_sel = 2'd0; e_dwe = 1'b0; e_owe = 1'b0;
        e_rwe = 1'b0; e_rta = 1'b0; e_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = 0;
        qa.delete();
        qb.delete();
        m_op = 1'b0;
        m_ovf = 1'b0;
        m_dout = 4'd0;
    endtask

    task automatic model_expect();
        int n;
        n = (m_phase == 0) ? qa.size() : qb.size();
        case (m_phase)
            0:       e_oe = (n == 0) ? 2'd0 : 2'd1;
            1:       e_oe = (n == 0) ? 2'd1 : 2'd2;
            2:       e_oe = 2'd3;
            default: e_oe = 2'd0;
        endcase
        e_state = 3'(m_phase);
        e_ocode = m_op;
        e_ovf   = m_ovf;
        e_dout  = m_dout;
    endtask

    task automatic model_idle();
        zero_pulses();
        if (m_phase == 3) m_phase = 0;
    endtask

    task automatic model_press(input logic t, input logic [3:0] c);
        zero_pulses();
        if (m_phase == 3) begin
            m_phase = 0;
        end else if (t && c == 4'hF) begin
            m_phase = 3;
            qa.delete();
            qb.delete();
            m_op = 1'b0;
            m_ovf = 1'b0;
            e_clr = 1'b1;
        end else if (!t && c <= 4'd9) begin
            if (m_phase == 0 || m_phase == 1) begin
                if (((m_phase == 0) ? qa.size() : qb.size()) < DIGITS) begin
                    if (m_phase == 0) qa.push_back(int'(c));
                    else              qb.push_back(int'(c));
                    e_dwe  = 1'b1;
                    e_sel  = 2'(m_phase + 1);
                    m_dout = c;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end else if (t && (c == 4'hA || c == 4'hB)) begin
            if (m_phase == 0 && qa.size() > 0) begin
                e_owe = 1'b1; m_op = c[0]; m_phase = 1; qb.delete();
            end else if (m_phase == 1 && qb.size() == 0) begin
                e_owe = 1'b1; m_op = c[0];
            end else if (m_phase == 2) begin
                e_owe = 1'b1; e_rta = 1'b1; m_op = c[0]; m_phase = 1; qb.delete();
            end
        end else if (t && c == 4'hC && m_phase == 1 && qb.size() > 0) begin
            e_rwe = 1'b1;
            e_sel = 2'd3;
            m_phase = 2;
        end
    endtask

    // press a key against the model, hold it, release, then idle for gap cycles
    task automatic press_model(input logic t, input logic [3:0] c, input int hold, input int gap);
        key_type = t; key_code = c; key_valid = 1'b1;
        tick();
        model_press(t, c); model_expect(); check_all("press");
        for (int h = 1; h < hold; h++) begin
            tick(); model_idle(); model_expect(); check_all("held");
        end
        key_valid = 1'b0;
        key_type = 1'($urandom);
        key_code = 4'($urandom);
        for (int g = 0; g < gap; g++) begin
            tick(); model_idle(); model_expect(); check_all("idle");
        end
    endtask

    task automatic table_idle();
        zero_pulses();
        if (e_state == 3'd3) e_state = 3'd0;
    endtask

    initial begin
        //              t  c      hold sel  dwe dout  owe oc rwe rta clr oe   ovf st
        tbl[0]  = '{1'b0, 4'd7,  20, 2'd1, 1, 4'd7, 0, 0, 0, 0, 0, 2'd1, 0, 3'd0};
        tbl[1]  = '{1'b0, 4'd2,   1, 2'd1, 1, 4'd2, 0, 0, 0, 0, 0, 2'd1, 0, 3'd0};
        tbl[2]  = '{1'b0, 4'd3,   1, 2'd1, 1, 4'd3, 0, 0, 0, 0, 0, 2'd1, 0, 3'd0};
        tbl[3]  = '{1'b0, 4'd4,   2, 2'd1, 1, 4'd4, 0, 0, 0, 0, 0, 2'd1, 0, 3'd0};
        tbl[4]  = '{1'b0, 4'd5,   1, 2'd0, 0, 4'd4, 0, 0, 0, 0, 0, 2'd1, 1, 3'd0};
        tbl[5]  = '{1'b1, 4'hF,   1, 2'd0, 0, 4'd4, 0, 0, 0, 0, 1, 2'd0, 0, 3'd3};
        tbl[6]  = '{1'b1, 4'hA,   1, 2'd0, 0, 4'd4, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
        tbl[7]  = '{1'b1, 4'hC,   1, 2'd0, 0, 4'd4, 0, 0, 0, 0, 0, 2'd0, 0, 3'd0};
        tbl[8]  = '{1'b0, 4'd3,   1, 2'd1, 1, 4'd3, 0, 0, 0, 0, 0, 2'd1, 0, 3'd0};
        tbl[9]  = '{1'b1, 4'hA,   1, 2'd0, 0, 4'd3, 1, 0, 0, 0, 0, 2'd1, 0, 3'd1};
        tbl[10] = '{1'b1, 4'hB,   1, 2'd0, 0, 4'd3, 1, 1, 0, 0, 0, 2'd1, 0, 3'd1};
        tbl[11] = '{1'b0, 4'd2,   1, 2'd2, 1, 4'd2, 0, 1, 0, 0, 0, 2'd2, 0, 3'd1};
        tbl[12] = '{1'b1, 4'hC,   1, 2'd3, 0, 4'd2, 0, 1, 1, 0, 0, 2'd3, 0, 3'd2};
        tbl[13] = '{1'b0, 4'd9,   1, 2'd0, 0, 4'd2, 0, 1, 0, 0, 0, 2'd3, 0, 3'd2};
        tbl[14] = '{1'b1, 4'hA,   3, 2'd0, 0, 4'd2, 1, 0, 0, 1, 0, 2'd1, 0, 3'd1};
        tbl[15] = '{1'b1, 4'hB,   1, 2'd0, 0, 4'd2, 1, 1, 0, 0, 0, 2'd1, 0, 3'd1};
        tbl[16] = '{1'b0, 4'hC,   1, 2'd0, 0, 4'd2, 0, 1, 0, 0, 0, 2'd1, 0, 3'd1};
        tbl[17] = '{1'b1, 4'hD,   1, 2'd0, 0, 4'd2, 0, 1, 0, 0, 0, 2'd1, 0, 3'd1};
        tbl[18] = '{1'b0, 4'd8,   1, 2'd2, 1, 4'd8, 0, 1, 0, 0, 0, 2'd2, 0, 3'd1};
        tbl[19] = '{1'b1, 4'hA,   1, 2'd0, 0, 4'd8, 0, 1, 0, 0, 0, 2'd2, 0, 3'd1};
        tbl[20] = '{1'b1, 4'hF,   1, 2'd0, 0, 4'd8, 0, 0, 0, 0, 1, 2'd0, 0, 3'd3};

        // reset state
        zero_pulses();
        e_dout = 4'd0; e_ocode = 1'b0; e_oe = 2'd0; e_ovf = 1'b0; e_state = 3'd0;
        #2;
        check_all("reset");
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check_all("post_reset");

        // directed table
        for (int i = 0; i < NV; i++) begin
            key_type = tbl[i].t; key_code = tbl[i].c; key_valid = 1'b1;
            tick();
            e_sel = tbl[i].sel; e_dwe = tbl[i].dwe; e_dout = tbl[i].dout;
            e_owe = tbl[i].owe; e_ocode = tbl[i].ocode; e_rwe = tbl[i].rwe;
            e_rta = tbl[i].rta; e_clr = tbl[i].clr; e_oe = tbl[i].oe;
            e_ovf = tbl[i].ovf; e_state = tbl[i].st;
            check_all($sformatf("vec%0d", i));
            for (int h = 1; h < tbl[i].hold; h++) begin
                tick(); table_idle(); check_all($sformatf("vec%0d_hold", i));
            end
            key_valid = 1'b0;
            tick(); table_idle(); check_all($sformatf("vec%0d_rel", i));
        end

        // reset asserted mid ENTRY_B with key 5 held
        model_reset();
        m_dout = 4'd8;
        press_model(1'b0, 4'd1, 1, 1);
        press_model(1'b1, 4'hA, 1, 1);
        key_type = 1'b0; key_code = 4'd5; key_valid = 1'b1;
        tick(); model_press(1'b0, 4'd5); model_expect(); check_all("rst_pre");
        tick(); model_idle(); model_expect(); check_all("rst_hold");
        reset_n = 1'b0;
        #1;
        model_reset(); zero_pulses(); model_expect(); check_all("rst_async");
        tick(); check_all("rst_low");
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); model_idle(); model_expect(); check_all("rst_held_key");
        end
        key_valid = 1'b0;
        tick(); model_idle(); model_expect(); check_all("rst_release");
        press_model(1'b0, 4'd5, 1, 2);

        // randomized presses against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            logic t;
            logic [3:0] c;
            r = $urandom_range(0, 99);
            if (r < 55)      begin t = 1'b0; c = 4'($urandom_range(0, 9)); end
            else if (r < 60) begin t = 1'b0; c = 4'($urandom_range(10, 15)); end
            else if (r < 70) begin t = 1'b1; c = 4'hA; end
            else if (r < 78) begin t = 1'b1; c = 4'hB; end
            else if (r < 88) begin t = 1'b1; c = 4'hC; end
            else if (r < 91) begin t = 1'b1; c = 4'hF; end
            else begin
                t = 1'b1;
                c = 4'($urandom_range(0, 11));
                if (c > 4'd9) c = c + 4'd3;
            end
            press_model(t, c, int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
